intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Parametrised vectored interrupt controller; next generation of the CPU's 8-line interrupt manager.
- Sits between the external `intr_in` lines and the control unit (`uc`).
- Latches rising edges per channel and applies a per-channel enable mask.
- Selects the highest-priority request, supports nested service via an in-service register, and hands the CPU a vector number through a call/return handshake.

Parameters:
- N_IRQ, 8, number of interrupt channels (2..32); channel 0 is highest priority.
- ID_W, 3, width of the channel index; must satisfy 2**ID_W >= N_IRQ.
- EN_RST, {N_IRQ{1'b1}}, reset value of the enable mask.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- intr_in  in  N_IRQ  interrupt lines; synchronous to clk, edge-triggered.
- en_we  in  1  write strobe for the enable mask.
- en_din  in  N_IRQ  new enable mask; 1 = channel enabled.
- call_ack  in  1  one-cycle pulse from `uc`: CPU is entering the ISR for `irq_id`.
- ret  in  1  one-cycle pulse from `uc`: return-from-interrupt executed.
- irq_req  out  1  interrupt request to `uc`.
- irq_id  out  ID_W  index of the selected channel; valid while irq_req = 1, otherwise 0.
- pending  out  N_IRQ  latched-edge register.
- in_service  out  N_IRQ  in-service register.
- en_mask  out  N_IRQ  current enable mask.
- ret_err  out  1  one-cycle pulse: ret received while in_service = 0.

Behaviour:
- Reset (synchronous, dominates every other input):
  - pending = 0, in_service = 0, en_mask = EN_RST, ret_err = 0.
  - Previous-sample register = all 1s, so a line already high at reset release does not generate an edge.
  - irq_req = 0 and irq_id = 0 in the cycle after reset.
  - A reset in mid-service discards all pending and in-service state.
- Edge detection:
  - Edge on channel i in cycle t: intr_in[i] = 1 and prev[i] = 0.
  - pending[i] is set at the clock edge ending cycle t; prev <= intr_in every cycle.
  - Pending latches regardless of en_mask; the mask gates requests only.
- Selection (combinational from registers):
  - cand = pending & en_mask.
  - p = lowest set index in cand; s = lowest set index in in_service (s = N_IRQ if in_service = 0).
  - irq_req = 1 iff cand != 0 and p < s (strict preemption; equal or lower priority waits); irq_id = p.
- Latency: input edge to irq_req = 1 cycle.
- call_ack:
  - If irq_req = 1: clear pending[irq_id] and set in_service[irq_id] at the next edge.
  - If irq_req = 0: ignored; no state change.
- ret:
  - Clears the lowest-indexed set bit of in_service, i.e. the innermost nesting level.
  - If in_service = 0: no state change, and ret_err pulses for 1 cycle.
- Simultaneous events:
  - call_ack and ret in the same cycle: ret clears bit s of the old in_service, and call_ack sets bit p; both apply at the same edge.
  - A new edge on channel i in the same cycle as call_ack clears pending[i]: the new edge wins, pending[i] stays 1, and in_service[i] is still set.
  - en_we in the same cycle as call_ack: call_ack uses the old mask (the registered irq_id is already decided); the new mask applies from the next cycle.
- Masking a pending channel holds it pending. Re-enabling it raises the request the following cycle.

Optional Feature:
- Macro: INTR_NEST_EN
- Defined: nesting as specified above; up to N_IRQ simultaneous in-service levels.
- Undefined:
  - irq_req is forced to 0 whenever in_service != 0; at most one bit of in_service is ever set.
  - ret clears that bit.
  - The p < s comparator is not synthesised.

Test Plan:
- Reset with intr_in = 8'h01 held high, release reset -> pending stays 0 and irq_req = 0; drop the line, raise it again -> pending = 8'h01, irq_req = 1, irq_id = 0 one cycle later.
- Edges on channels 5 and 2 in the same cycle -> irq_id = 2; call_ack -> in_service = 8'h04, pending = 8'h20, irq_req = 0 (5 > 2).
- With INTR_NEST_EN, in_service = 8'h20, edge on channel 1 -> irq_req = 1, irq_id = 1; call_ack -> in_service = 8'h22; ret -> 8'h20; ret -> 8'h00.
- en_din = 8'hF7 written, edge on channel 3 -> pending[3] = 1, irq_req = 0; write 8'hFF -> irq_req = 1, irq_id = 3 the next cycle.
- ret with in_service = 0 -> ret_err pulses exactly 1 cycle, other state unchanged.
- Edge on channel 4 coincident with call_ack for channel 4 -> in_service[4] = 1, pending[4] remains 1; without INTR_NEST_EN, irq_req stays 0 until ret.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: request/acknowledge and register-view bundle between intr_ctrl and the control unit
interface intr_ctrl_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] intr_in;
    logic             en_we;
    logic [N_IRQ-1:0] en_din;
    logic             call_ack;
    logic             ret;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] in_service;
    logic [N_IRQ-1:0] en_mask;
    logic             ret_err;

    modport master (
        output intr_in, en_we, en_din, call_ack, ret,
        input  irq_req, irq_id, pending, in_service, en_mask, ret_err
    );

    modport slave (
        input  intr_in, en_we, en_din, call_ack, ret,
        output irq_req, irq_id, pending, in_service, en_mask, ret_err
    );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: vectored edge-triggered interrupt controller with priority select and in-service tracking
// INTR_NEST_EN defined enables nested preemption; undefined allows a single in-service level.
module intr_ctrl #(
    parameter int               N_IRQ  = 8,
    parameter int               ID_W   = 3,
    parameter logic [N_IRQ-1:0] EN_RST = {N_IRQ{1'b1}}
) (
    input logic        clk,
    input logic        reset,
    intr_ctrl_if.slave bus
);
    localparam int SW = ID_W + 1;

    logic [N_IRQ-1:0] pending, in_service, en_mask, prev;
    logic             ret_err;
    logic [N_IRQ-1:0] cand, p_hot, s_hot, edges, ack_set, ret_clr;
    logic [ID_W-1:0]  p;
    logic             req, ack, ret_ok;

    // Lowest set index wins: scan from the top so the last hit is the highest priority.
    always_comb begin
        cand  = pending & en_mask;
        p     = '0;
        p_hot = '0;
        s_hot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                p        = ID_W'(i);
                p_hot    = '0;
                p_hot[i] = 1'b1;
            end
            if (in_service[i]) begin
                s_hot    = '0;
                s_hot[i] = 1'b1;
            end
        end
    end

`ifdef INTR_NEST_EN
    logic [SW-1:0] s;

    always_comb begin
        s = SW'(N_IRQ);
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (in_service[i]) s = SW'(i);
    end

    assign req = (|cand) && ({1'b0, p} < s);
`else
    assign req = (|cand) && !(|in_service);
`endif

    assign ack     = bus.call_ack & req;
    assign ret_ok  = bus.ret & (|in_service);
    assign edges   = bus.intr_in & ~prev;
    assign ack_set = ack ? p_hot : '0;
    assign ret_clr = ret_ok ? s_hot : '0;

    // A fresh edge re-arms the channel even in the cycle its old request is acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            in_service <= '0;
            en_mask    <= EN_RST;
            prev       <= '1;
            ret_err    <= 1'b0;
        end else begin
            pending    <= (pending & ~ack_set) | edges;
            in_service <= (in_service & ~ret_clr) | ack_set;
            en_mask    <= bus.en_we ? bus.en_din : en_mask;
            prev       <= bus.intr_in;
            ret_err    <= bus.ret & ~(|in_service);
        end
    end

    assign bus.irq_req    = req;
    assign bus.irq_id     = req ? p : '0;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;
    assign bus.en_mask    = en_mask;
    assign bus.ret_err    = ret_err;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vector table plus hand sequences for intr_ctrl (N_IRQ=8)
module tb_intr_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    intr_ctrl_if #(.N_IRQ(8), .ID_W(3)) bus ();
    intr_ctrl #(.N_IRQ(8), .ID_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] intr;
        logic       we;
        logic [7:0] din;
        logic       ack;
        logic       ret;
        logic       req;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] isv;
        logic [7:0] mask;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [7:0] intr, input logic we, input logic [7:0] din,
                       input logic ack, input logic rt);
        reset        = r;
        bus.intr_in  = intr;
        bus.en_we    = we;
        bus.en_din   = din;
        bus.call_ack = ack;
        bus.ret      = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [2:0] id, input logic [7:0] pend,
                           input logic [7:0] isv, input logic [7:0] mask, input logic err);
        chk({tag, " irq_req"}, 32'(bus.irq_req), 32'(req));
        chk({tag, " irq_id"}, 32'(bus.irq_id), 32'(id));
        chk({tag, " pending"}, 32'(bus.pending), 32'(pend));
        chk({tag, " in_service"}, 32'(bus.in_service), 32'(isv));
        chk({tag, " en_mask"}, 32'(bus.en_mask), 32'(mask));
        chk({tag, " ret_err"}, 32'(bus.ret_err), 32'(err));
    endtask

    initial begin
        //                rst  intr  we  din   ack  ret  req  id   pend   isv    mask   err
        vecs.push_back('{1'b1, 8'h01, 0, 8'h00, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b1, 8'h01, 0, 8'h00, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h01, 0, 8'h00, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h01, 0, 8'h00, 0, 0,   1, 3'd0, 8'h01, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 1, 0,   0, 3'd0, 8'h00, 8'h01, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 1});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h24, 0, 8'h00, 0, 0,   1, 3'd2, 8'h24, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 1, 0,   0, 3'd0, 8'h20, 8'h04, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   1, 3'd5, 8'h20, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 1, 0,   0, 3'd0, 8'h00, 8'h20, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 1, 8'hF7, 0, 0,   0, 3'd0, 8'h00, 8'h00, 8'hF7, 0});
        vecs.push_back('{1'b0, 8'h08, 0, 8'h00, 0, 0,   0, 3'd0, 8'h08, 8'h00, 8'hF7, 0});
        vecs.push_back('{1'b0, 8'h00, 1, 8'hFF, 0, 0,   1, 3'd3, 8'h08, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 1, 8'h00, 1, 0,   0, 3'd0, 8'h00, 8'h08, 8'h00, 0});
        vecs.push_back('{1'b0, 8'h00, 1, 8'hFF, 0, 1,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h10, 0, 8'h00, 0, 0,   1, 3'd4, 8'h10, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 0,   1, 3'd4, 8'h10, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h10, 0, 8'h00, 1, 0,   0, 3'd0, 8'h10, 8'h10, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 0,   0, 3'd0, 8'h10, 8'h10, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   1, 3'd4, 8'h10, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 1, 0,   0, 3'd0, 8'h00, 8'h10, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 0, 1,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});
        vecs.push_back('{1'b0, 8'h00, 0, 8'h00, 1, 0,   0, 3'd0, 8'h00, 8'h00, 8'hFF, 0});

        foreach (vecs[k]) begin
            cyc(vecs[k].rst, vecs[k].intr, vecs[k].we, vecs[k].din, vecs[k].ack, vecs[k].ret);
            chk_all($sformatf("row%0d", k), vecs[k].req, vecs[k].id, vecs[k].pend,
                    vecs[k].isv, vecs[k].mask, vecs[k].err);
        end

        // reset in mid-service discards pending/in-service and restores the mask
        cyc(0, 8'h08, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        cyc(0, 8'h40, 1, 8'h0F, 0, 0);
        chk_all("pre_reset", 0, 3'd0, 8'h40, 8'h08, 8'h0F, 0);
        cyc(1, 8'h40, 0, 8'h00, 1, 1);
        chk_all("mid_reset", 0, 3'd0, 8'h00, 8'h00, 8'hFF, 0);
        cyc(0, 8'h40, 0, 8'h00, 0, 0);
        chk_all("post_reset", 0, 3'd0, 8'h00, 8'h00, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 0, 0);

`ifdef INTR_NEST_EN
        cyc(0, 8'h20, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        cyc(0, 8'h02, 0, 8'h00, 0, 0);
        chk_all("nest_preempt", 1, 3'd1, 8'h02, 8'h20, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        chk_all("nest_ack", 0, 3'd0, 8'h00, 8'h22, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        chk_all("nest_ret1", 0, 3'd0, 8'h00, 8'h20, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        chk_all("nest_ret2", 0, 3'd0, 8'h00, 8'h00, 8'hFF, 0);
        cyc(0, 8'h20, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        cyc(0, 8'h02, 0, 8'h00, 0, 0);
        chk_all("nest_pre_both", 1, 3'd1, 8'h02, 8'h20, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        chk_all("nest_ack_ret", 0, 3'd0, 8'h00, 8'h02, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        chk_all("nest_ret3", 0, 3'd0, 8'h00, 8'h00, 8'hFF, 0);
`else
        cyc(0, 8'h20, 0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        cyc(0, 8'h02, 0, 8'h00, 0, 0);
        chk_all("flat_blocked", 0, 3'd0, 8'h02, 8'h20, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0);
        chk_all("flat_ack_ignored", 0, 3'd0, 8'h02, 8'h20, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        chk_all("flat_ret", 1, 3'd1, 8'h02, 8'h00, 8'hFF, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 1);
        chk_all("flat_ack_ret", 0, 3'd0, 8'h00, 8'h02, 8'hFF, 1);
        cyc(0, 8'h00, 0, 8'h00, 0, 1);
        chk_all("flat_ret2", 0, 3'd0, 8'h00, 8'h00, 8'hFF, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
